// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one memory port between instruction fetch and the LSU.
// When both masters request at once, the master that did not get the last grant wins.
package pipeline;
   localparam int XLEN = 32;
endpackage

module mem_arbiter
   import pipeline::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_re,
   input  logic [XLEN-1:0]   i_addr,
   output logic              i_ack,
   input  logic              d_re,
   input  logic              d_we,
   input  logic [XLEN/8-1:0] d_sel,
   input  logic [XLEN-1:0]   d_addr,
   input  logic [XLEN-1:0]   d_w,
   output logic              d_ack,
   output logic [XLEN-1:0]   r_data,
   output logic              m_re,
   output logic              m_we,
   output logic [XLEN/8-1:0] m_sel,
   output logic [XLEN-1:0]   m_addr,
   output logic [XLEN-1:0]   m_w,
   input  logic              m_ack,
   input  logic [XLEN-1:0]   m_r
);

   // state | meaning
   // IDLE  | no grant; m_ack ignored; arbitrate pending requests
   // GNT_I | fetch owns the port until m_ack or fetch drops i_re
   // GNT_D | LSU owns the port until m_ack or LSU drops d_re/d_we
   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

   state_t r_state;
   logic   r_last_d;
   logic   w_d_req;

   assign w_d_req = d_re | d_we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_last_d <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               // fetch wins only when LSU is silent or the LSU had the last grant
               if (i_re && (!w_d_req || r_last_d)) begin
                  r_state  <= GNT_I;
                  r_last_d <= 1'b0;
               end else if (w_d_req) begin
                  r_state  <= GNT_D;
                  r_last_d <= 1'b1;
               end
            end
            GNT_I: if (m_ack || !i_re)    r_state <= IDLE;
            GNT_D: if (m_ack || !w_d_req) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      m_re   = 1'b0;
      m_we   = 1'b0;
      m_sel  = '0;
      m_addr = '0;
      m_w    = '0;
      case (r_state)
         GNT_I: begin
            m_re   = 1'b1;
            m_sel  = '1;
            m_addr = i_addr;
         end
         GNT_D: begin
            m_re   = d_re;
            m_we   = d_we;
            m_sel  = d_sel;
            m_addr = d_addr;
            m_w    = d_w;
         end
         default: ;
      endcase
   end

   assign i_ack  = m_ack && (r_state == GNT_I);
   assign d_ack  = m_ack && (r_state == GNT_D);
   assign r_data = m_r;

endmodule
